// File: rtl/keypad_num_entry.sv
// Keypad operand entry: turns key events into a signed BCD word {sign, d[N-1]..d0}
// and hands the finished operand to the datapath over a valid/ack handshake.
module keypad_num_entry #(
    parameter int MAX_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    key_valid,
    input  logic [4:0]              key_code,
    output logic                    key_ready,
    input  logic                    num_ack,
    output logic [4*MAX_DIGITS:0]   num_out,
    output logic                    num_valid,
    output logic [2:0]              digit_cnt,
    output logic                    overflow
);

    localparam int W = 4*MAX_DIGITS + 1;

    localparam logic [4:0] KEY_CLR  = 5'd10;
    localparam logic [4:0] KEY_BSP  = 5'd11;
    localparam logic [4:0] KEY_SIGN = 5'd12;
    localparam logic [4:0] KEY_ENT  = 5'd13;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        PRESENT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   num_q, num_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;
    logic           ready_q, ready_d;

    logic           accept;
    logic           is_digit;
    logic [3:0]     digit;
    logic [W-2:0]   mag;
    logic           mag_zero;
    logic           cnt_full;

    assign accept   = key_valid & ready_q;
    assign is_digit = (key_code < 5'd10);
    assign digit    = key_code[3:0];
    assign mag      = num_q[W-2:0];
    assign mag_zero = (mag == '0);
    assign cnt_full = (cnt_q == 3'(MAX_DIGITS));

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovf_d   = 1'b0;

        // Clear bypasses key_ready so a stuck presentation can always be aborted.
        if (key_valid && key_code == KEY_CLR) begin
            num_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = ENTRY;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (accept) begin
                        if (is_digit) begin
                            if (cnt_full) begin
                                ovf_d = 1'b1;
                            end else if (mag_zero) begin
                                if (digit != 4'd0) begin
                                    num_d = {num_q[W-1], {(W-5){1'b0}}, digit};
                                    cnt_d = 3'd1;
                                end
                            end else begin
                                num_d = {num_q[W-1], mag[W-6:0], digit};
                                cnt_d = cnt_q + 3'd1;
                            end
                        end else if (key_code == KEY_BSP) begin
                            if (cnt_q != 3'd0) begin
                                num_d = {num_q[W-1], 4'd0, mag[W-2:4]};
                                cnt_d = cnt_q - 3'd1;
                            end
                        end else if (key_code == KEY_SIGN) begin
                            num_d[W-1] = ~num_q[W-1];
                        end else if (key_code == KEY_ENT) begin
                            valid_d = 1'b1;
                            state_d = PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (num_ack && valid_q) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (accept) begin
                        if (is_digit) begin
                            // New entry starts from a clean, positive zero.
                            num_d   = {1'b0, {(W-5){1'b0}}, digit};
                            cnt_d   = (digit != 4'd0) ? 3'd1 : 3'd0;
                            state_d = ENTRY;
                        end else if (key_code == KEY_SIGN) begin
                            num_d[W-1] = ~num_q[W-1];
                        end else if (key_code == KEY_ENT) begin
                            valid_d = 1'b1;
                            state_d = PRESENT;
                        end
                    end
                end
                default: state_d = ENTRY;
            endcase
        end

        ready_d = (state_d != PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTRY;
            num_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
        end
    end

    assign num_out   = num_q;
    assign digit_cnt = cnt_q;
    assign num_valid = valid_q;
    assign overflow  = ovf_q;
    assign key_ready = ready_q;

endmodule

// File: tb/tb_keypad_num_entry.sv
// Directed bench for keypad_num_entry: hand-computed operand words and handshake checks.
module tb_keypad_num_entry;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_ready;
    logic        num_ack;
    logic [20:0] num_out;
    logic        num_valid;
    logic [2:0]  digit_cnt;
    logic        overflow;

    int n_vec;
    int n_err;
    int ovf_cnt;

    keypad_num_entry #(.MAX_DIGITS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .num_ack   (num_ack),
        .num_out   (num_out),
        .num_valid (num_valid),
        .digit_cnt (digit_cnt),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (overflow) ovf_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one key for one cycle; returns at the negedge after the capturing edge.
    task automatic press(input logic [4:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 5'd0;
    endtask

    task automatic chk_word(input string tag, input logic [20:0] w, input logic [2:0] c);
        chk({tag, ".num"}, 32'(num_out), 32'(w));
        chk({tag, ".cnt"}, 32'(digit_cnt), 32'(c));
    endtask

    initial begin
        n_vec = 0; n_err = 0; ovf_cnt = 0;
        rst_n = 1'b0; key_valid = 1'b0; key_code = 5'd0; num_ack = 1'b0;

        #12;
        chk("rst.num",   32'(num_out), 32'h0);
        chk("rst.cnt",   32'(digit_cnt), 32'h0);
        chk("rst.valid", 32'(num_valid), 32'h0);
        chk("rst.ovf",   32'(overflow), 32'h0);
        chk("rst.ready", 32'(key_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Leading zeros suppressed, then 1,2,3
        press(5'd0);
        chk_word("lz0", 21'h000000, 3'd0);
        press(5'd0);
        press(5'd1);
        chk_word("d1", 21'h000001, 3'd1);
        press(5'd2);
        press(5'd3);
        chk_word("d123", 21'h000123, 3'd3);
        chk("d123.noovf", 32'(ovf_cnt), 32'd0);

        // Fill to capacity, sixth digit overflows
        press(5'd10);
        chk_word("clr", 21'h000000, 3'd0);
        press(5'd9); press(5'd8); press(5'd7); press(5'd6); press(5'd5);
        chk_word("full", 21'h098765, 3'd5);
        chk("full.ovf0", 32'(overflow), 32'h0);
        press(5'd4);
        chk("ovf.pulse", 32'(overflow), 32'h1);
        chk_word("ovf", 21'h098765, 3'd5);
        @(negedge clk);
        chk("ovf.drop", 32'(overflow), 32'h0);
        chk("ovf.count", 32'(ovf_cnt), 32'd1);

        // Backspace, sign, enter, hold
        press(5'd10);
        press(5'd1); press(5'd2); press(5'd3);
        press(5'd11);
        chk_word("bsp", 21'h000012, 3'd2);
        press(5'd12);
        chk_word("sign", 21'h100012, 3'd2);
        press(5'd13);
        for (int i = 0; i < 5; i++) begin
            chk("hold.valid", 32'(num_valid), 32'h1);
            chk("hold.ready", 32'(key_ready), 32'h0);
            chk_word("hold", 21'h100012, 3'd2);
            if (i == 0) begin
                key_valid = 1'b1; key_code = 5'd4;
            end else if (i == 2) begin
                key_valid = 1'b1; key_code = 5'd11;
            end else begin
                key_valid = 1'b0; key_code = 5'd0;
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        chk_word("hold.end", 21'h100012, 3'd2);
        num_ack = 1'b1;
        @(negedge clk);
        num_ack = 1'b0;
        chk("ack.valid", 32'(num_valid), 32'h0);
        chk("ack.ready", 32'(key_ready), 32'h1);

        // DONE: backspace no-op, sign toggles twice, digit starts fresh entry
        press(5'd11);
        chk_word("done.bsp", 21'h100012, 3'd2);
        press(5'd12);
        chk_word("done.sign", 21'h000012, 3'd2);
        press(5'd12);
        chk_word("done.sign2", 21'h100012, 3'd2);
        press(5'd7);
        chk_word("done.d7", 21'h000007, 3'd1);
        press(5'd8);
        chk_word("entry.d78", 21'h000078, 3'd2);
        press(5'd11);
        chk_word("entry.bsp", 21'h000007, 3'd1);
        press(5'd13);
        chk("ent1.valid", 32'(num_valid), 32'h1);
        num_ack = 1'b1;
        @(negedge clk);
        num_ack = 1'b0;
        chk("ack2.valid", 32'(num_valid), 32'h0);
        press(5'd13);
        chk("re.valid", 32'(num_valid), 32'h1);
        chk_word("re", 21'h000007, 3'd1);

        // Clear beats simultaneous ack in PRESENT
        key_valid = 1'b1; key_code = 5'd10; num_ack = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; key_code = 5'd0; num_ack = 1'b0;
        chk_word("clrack", 21'h000000, 3'd0);
        chk("clrack.valid", 32'(num_valid), 32'h0);
        chk("clrack.ready", 32'(key_ready), 32'h1);

        // Stray ack outside PRESENT is ignored
        num_ack = 1'b1;
        press(5'd4);
        num_ack = 1'b0;
        press(5'd5);
        chk_word("d45", 21'h000045, 3'd2);
        chk("d45.valid", 32'(num_valid), 32'h0);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_word("arst", 21'h000000, 3'd0);
        chk("arst.ready", 32'(key_ready), 32'h1);
        chk("arst.valid", 32'(num_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reserved codes change nothing
        press(5'd14);
        chk_word("rsv14", 21'h000000, 3'd0);
        press(5'd3);
        press(5'd31);
        chk_word("rsv31", 21'h000003, 3'd1);
        press(5'd14);
        chk_word("rsv14b", 21'h000003, 3'd1);
        chk("rsv.valid", 32'(num_valid), 32'h0);
        chk("rsv.ovf", 32'(ovf_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
